// File: rtl/icap_multiboot_seq_if.sv
// icap_multiboot_seq_if
// Groups the host request/status signals and the ICAP pin bundle of the
// multiboot sequencer.
//   start_i, boot_addr_i          : host reboot request and target flash address
//   busy_o, done_o, word_idx_o    : sequencer status back to the host
//   icap_clk_o, icap_ce_n_o,
//   icap_wr_n_o, icap_din_o       : ICAP clock, strobes and data
//   icap_busy_i                   : ICAP BUSY
// The slave modport is the sequencer's view. The master modport is the view
// of whatever drives requests and models the ICAP.
interface icap_multiboot_seq_if;
  logic        start_i;
  logic [23:0] boot_addr_i;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  word_idx_o;
  logic        icap_clk_o;
  logic        icap_ce_n_o;
  logic        icap_wr_n_o;
  logic [15:0] icap_din_o;
  logic        icap_busy_i;

  modport slave (
    input  start_i, boot_addr_i, icap_busy_i,
    output busy_o, done_o, word_idx_o,
    output icap_clk_o, icap_ce_n_o, icap_wr_n_o, icap_din_o
  );

  modport master (
    output start_i, boot_addr_i, icap_busy_i,
    input  busy_o, done_o, word_idx_o,
    input  icap_clk_o, icap_ce_n_o, icap_wr_n_o, icap_din_o
  );
endinterface

// File: rtl/icap_multiboot_seq.sv
// icap_multiboot_seq
// Drives the Spartan-6 ICAP through the 16-word IPROG command stream so that
// the FPGA warm-reboots into the bitstream at a host-selected flash address.
// The ICAP clock is divided down from clk, and all ICAP pins change only at
// the start of the low phase.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : icap_multiboot_seq_if.slave (host request/status + ICAP pins)
//
// state  | meaning
// IDLE   | waiting for start_i; ICAP pins released
// ALIGN  | request accepted, waiting for the next ICAP period boundary
// WRITE  | presenting word idx; it advances once a BUSY-free rising edge has consumed it
// DONE   | stream finished; pins released, done_o issued next cycle
module icap_multiboot_seq #(
  parameter int          CLK_DIV     = 8,
  parameter logic [23:0] GOLDEN_ADDR = 24'h000000,
  parameter bit          BITSWAP     = 1'b1
) (
  input logic                 clk,
  input logic                 reset_n,
  icap_multiboot_seq_if.slave bus
);

  localparam int CW   = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_WRITE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [23:0]   addr_q, addr_d;
  logic          taken_q, taken_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ce_n_q, ce_n_d;
  logic          wr_n_q, wr_n_d;
  logic [15:0]   din_q, din_d;
  logic          icap_clk_q, icap_clk_d;

  logic wrap, at_rise, consumed;

  function automatic logic [15:0] word_at(input logic [3:0] idx, input logic [23:0] a);
    logic [15:0] w;
    case (idx)
      4'd0:    w = 16'hFFFF;
      4'd1:    w = 16'hAA99;
      4'd2:    w = 16'h5566;
      4'd3:    w = 16'h3261;
      4'd4:    w = a[15:0];
      4'd5:    w = 16'h3281;
      4'd6:    w = {8'h03, a[23:16]};
      4'd7:    w = 16'h32A1;
      4'd8:    w = GOLDEN_ADDR[15:0];
      4'd9:    w = 16'h32C1;
      4'd10:   w = {8'h03, GOLDEN_ADDR[23:16]};
      4'd11:   w = 16'h30A1;
      4'd12:   w = 16'h000E;
      default: w = 16'h2000;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] byte_bitrev(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7-i];
      r[8 + i] = w[15-i];
    end
    return r;
  endfunction

  // The last cycle of an ICAP period; registered pin updates land on cnt==0.
  assign wrap    = (cnt_q == CW'(CLK_DIV - 1));
  assign at_rise = (cnt_q == CW'(HALF));
  // With CLK_DIV==2 the rising-edge cycle is also the wrap cycle, so the
  // live sample has to count alongside the stored one.
  assign consumed = taken_q | (at_rise & ~bus.icap_busy_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      taken_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      din_q      <= '0;
      icap_clk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      taken_q    <= taken_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ce_n_q     <= ce_n_d;
      wr_n_q     <= wr_n_d;
      din_q      <= din_d;
      icap_clk_q <= icap_clk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    taken_d = taken_q;
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    if (at_rise && !bus.icap_busy_i) taken_d = 1'b1;
    if (wrap) taken_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // done_q blocks a request arriving in the same cycle as the done pulse.
        if (bus.start_i && !done_q) begin
          state_d = S_ALIGN;
          addr_d  = bus.boot_addr_i;
        end
      end
      S_ALIGN: begin
        if (wrap) begin
          state_d = S_WRITE;
          idx_d   = '0;
        end
      end
      S_WRITE: begin
        if (wrap && consumed) begin
          if (idx_q == 4'd15) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output flops are loaded from next-state values so every pin is registered
  // and changes in the same cycle the state does.
  always_comb begin
    icap_clk_d = (cnt_d >= CW'(HALF));
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_DONE);
    ce_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    din_d      = '0;
    if (state_d == S_WRITE) begin
      ce_n_d = 1'b0;
      wr_n_d = 1'b0;
      din_d  = BITSWAP ? byte_bitrev(word_at(idx_d, addr_d)) : word_at(idx_d, addr_d);
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.word_idx_o  = idx_q;
  assign bus.icap_clk_o  = icap_clk_q;
  assign bus.icap_ce_n_o = ce_n_q;
  assign bus.icap_wr_n_o = wr_n_q;
  assign bus.icap_din_o  = din_q;

endmodule

// File: tb/tb_icap_multiboot_seq.sv
// tb_icap_multiboot_seq
// Three sequencer instances: 0 = CLK_DIV 8 / no bit swap, 1 = CLK_DIV 8 /
// bit swap, 2 = CLK_DIV 2 / no bit swap. Expected {word_idx, din} pairs are
// queued when a start is driven and popped as the ICAP model consumes words.
module tb_icap_multiboot_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  start_v = '0;
  logic [23:0] boot_v [3];
  logic [2:0]  ibusy_v = '0;
  logic [2:0]  mon_busy, mon_done, mon_iclk, mon_ce_n, mon_wr_n;
  logic [3:0]  mon_idx [3];
  logic [15:0] mon_din [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    icap_multiboot_seq_if bus_if ();
    assign bus_if.start_i     = start_v[k];
    assign bus_if.boot_addr_i = boot_v[k];
    assign bus_if.icap_busy_i = ibusy_v[k];
    assign mon_busy[k] = bus_if.busy_o;
    assign mon_done[k] = bus_if.done_o;
    assign mon_iclk[k] = bus_if.icap_clk_o;
    assign mon_ce_n[k] = bus_if.icap_ce_n_o;
    assign mon_wr_n[k] = bus_if.icap_wr_n_o;
    assign mon_idx[k]  = bus_if.word_idx_o;
    assign mon_din[k]  = bus_if.icap_din_o;
    icap_multiboot_seq #(
      .CLK_DIV     ((k == 2) ? 2 : 8),
      .GOLDEN_ADDR (24'h000000),
      .BITSWAP     ((k == 1) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if.slave)
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [19:0] exp_q [$];
  logic [15:0] basic_tbl [16];
  int sel = 0;
  int run_tag = 0;
  int busy_idx = -1;
  int busy_n = 0;

  function automatic logic [15:0] model_word(input int k, input int idx, input logic [23:0] a);
    logic [15:0] w;
    logic [15:0] r;
    case (idx)
      0:       w = 16'hFFFF;
      1:       w = 16'hAA99;
      2:       w = 16'h5566;
      3:       w = 16'h3261;
      4:       w = a[15:0];
      5:       w = 16'h3281;
      6:       w = {8'h03, a[23:16]};
      7:       w = 16'h32A1;
      8:       w = 16'h0000;
      9:       w = 16'h32C1;
      10:      w = 16'h0300;
      11:      w = 16'h30A1;
      12:      w = 16'h000E;
      default: w = 16'h2000;
    endcase
    r = w;
    if (k == 1) begin
      for (int b = 0; b < 8; b++) begin
        r[b]     = w[7-b];
        r[8 + b] = w[15-b];
      end
    end
    return r;
  endfunction

  // ICAP model: at each rising icap_clk with CE active, compare the presented
  // word with the queue head, decide BUSY for that edge, pop if consumed.
  int   mon_tag = -1;
  int   busy_used = 0;
  logic mclk_prev = 1'b0;
  always @(negedge clk) begin
    logic [19:0] obs;
    if (run_tag != mon_tag) begin
      mon_tag   = run_tag;
      busy_used = 0;
    end
    if (reset_n && mon_iclk[sel] && !mclk_prev && !mon_ce_n[sel]) begin
      obs = {mon_idx[sel], mon_din[sel]};
      if (exp_q.size() == 0) begin
        chk("sb_queue_depth", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("sb_word", 32'(obs), 32'(exp_q[0]));
        chk("sb_wr_n", 32'(mon_wr_n[sel]), 32'd0);
        if (int'(mon_idx[sel]) == busy_idx && busy_used < busy_n) begin
          ibusy_v[sel] = 1'b1;
          busy_used++;
        end else begin
          ibusy_v[sel] = 1'b0;
          void'(exp_q.pop_front());
        end
      end
    end
    mclk_prev = mon_iclk[sel];
  end

  int t0;

  // Caller is at a negedge; start is sampled at the next posedge (cycle t0).
  task automatic start_seq(input int k, input logic [23:0] a, input bit use_basic);
    start_v[k] = 1'b1;
    boot_v[k]  = a;
    for (int i = 0; i < 16; i++)
      exp_q.push_back({4'(i), use_basic ? basic_tbl[i] : model_word(k, i, a)});
    run_tag++;
    t0 = cyc;
    @(negedge clk);
    start_v[k] = 1'b0;
    chk("busy_after_start", 32'(mon_busy[k]), 32'd1);
  endtask

  // Returns at the negedge where done_o is seen.
  task automatic wait_done(input int k, input int inj_idx, output int w0, output int dc,
                           output int ncap, output int bcyc);
    bit   seen_w0 = 1'b0;
    bit   injected = 1'b0;
    logic pclk;
    pclk = mon_iclk[k];
    w0 = -1; dc = -1; ncap = 0; bcyc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (injected) start_v[k] = 1'b0;
      if (!mon_ce_n[k] && !seen_w0) begin
        seen_w0 = 1'b1;
        w0 = cyc;
      end
      if (!injected && !mon_ce_n[k] && int'(mon_idx[k]) == inj_idx) begin
        start_v[k] = 1'b1;
        boot_v[k]  = 24'hFFFFFF;
        injected   = 1'b1;
      end
      if (mon_iclk[k] && !pclk && !mon_ce_n[k]) ncap++;
      if (mon_busy[k]) bcyc++;
      pclk = mon_iclk[k];
      if (mon_done[k]) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    start_v[k] = 1'b0;
    if (dc < 0) chk("done_timeout", 32'(dc), 32'd0);
  endtask

  task automatic run_check(input string nm, input int k, input logic [23:0] a, input bit use_basic,
                           input int b_idx, input int b_n, input int inj_idx);
    int w0, dc, ncap, bcyc, d;
    d = (k == 2) ? 2 : 8;
    sel = k;
    busy_idx = b_idx;
    busy_n = b_n;
    start_seq(k, a, use_basic);
    wait_done(k, inj_idx, w0, dc, ncap, bcyc);
    chk({nm, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_captures"}, 32'(ncap), 32'(16 + b_n));
    chk({nm, "_latency"}, 32'(dc - w0), 32'(16 * d + 1 + b_n * d));
    chk({nm, "_align"}, 32'((w0 - t0 >= 2) && (w0 - t0 <= d + 1)), 32'd1);
    chk({nm, "_busy_len"}, 32'(bcyc), 32'(dc - t0 - 1));
    chk({nm, "_pins_at_done"}, {30'd0, mon_ce_n[k], mon_wr_n[k]}, 32'd3);
  endtask

  initial begin
    int   toggles, found;
    logic pv;
    logic done_seen, busy_seen;
    basic_tbl = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, 16'h3456, 16'h3281, 16'h0312, 16'h32A1,
                  16'h0000, 16'h32C1, 16'h0300, 16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000};
    for (int k = 0; k < 3; k++) boot_v[k] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {9'd0, mon_ce_n[0], mon_wr_n[0], mon_busy[0], mon_done[0], mon_iclk[0], mon_idx[0], mon_din[0]},
        {9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000});
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    run_check("basic", 0, 24'h123456, 1'b1, -1, 0, -1);
    repeat (3) @(negedge clk);

    run_check("bp", 0, 24'h00ABCD, 1'b0, 4, 3, -1);
    repeat (4) @(negedge clk);

    run_check("filt", 0, 24'h7E5A3C, 1'b0, -1, 0, 2);
    start_v[0] = 1'b1;
    boot_v[0]  = 24'h00C0DE;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("done_pulse_width", 32'(mon_done[0]), 32'd0);
    chk("start_in_done_ignored", 32'(mon_busy[0]), 32'd0);
    run_check("restart", 0, 24'h00C0DE, 1'b0, -1, 0, -1);
    repeat (3) @(negedge clk);

    run_check("swap", 1, 24'h123456, 1'b0, -1, 0, -1);
    repeat (3) @(negedge clk);

    run_check("div2", 2, 24'hA5C3E1, 1'b0, -1, 0, -1);
    toggles = 0;
    pv = mon_iclk[2];
    repeat (6) begin
      @(negedge clk);
      if (mon_iclk[2] != pv) toggles++;
      pv = mon_iclk[2];
    end
    chk("div2_toggle", 32'(toggles), 32'd6);

    sel = 0;
    busy_n = 0;
    start_seq(0, 24'h111111, 1'b0);
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      if (!mon_ce_n[0] && mon_idx[0] == 4'd7) found = 1;
      else @(negedge clk);
    end
    chk("reach_idx7", 32'(found), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_outs", {26'd0, mon_ce_n[0], mon_busy[0], mon_idx[0]}, {26'd0, 1'b1, 1'b0, 4'h0});
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 1'b0;
    busy_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      done_seen = done_seen | mon_done[0];
      busy_seen = busy_seen | mon_busy[0] | ~mon_ce_n[0];
    end
    chk("no_done_after_reset", 32'(done_seen), 32'd0);
    chk("idle_after_reset", 32'(busy_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
